seq_mag_compare: RTL and testbench

Sequential, parametrised magnitude comparator. It generalises the fixed 4-bit cascade comparator to `WIDTH` bits and adds signed/unsigned mode, a start/busy/done handshake, early termination and a reported index of the most significant differing bit. It scans one bit per cycle, MSB first, using a single cascade cell. It serves datapath control logic that can tolerate multi-cycle latency in exchange for minimal comparator area.

---
 rtl/seq_mag_compare_pkg.sv | 16 +
 rtl/seq_mag_compare_if.sv | 29 ++
 rtl/seq_mag_compare_cell.sv | 28 ++
 rtl/seq_mag_compare.sv | 118 +++++++++++
 tb/tb_seq_mag_compare.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_mag_compare_pkg.sv
// Shared types for the sequential magnitude comparator: FSM states and
// the one-hot {x,y,z} result encodings.
package compare_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] RES_GT   = 3'b100;
    localparam logic [2:0] RES_EQ   = 3'b010;
    localparam logic [2:0] RES_LT   = 3'b001;
    localparam logic [2:0] RES_NONE = 3'b000;

endpackage

// File: rtl/seq_mag_compare_if.sv
// Request/result bundle of seq_mag_compare; master drives the operands,
// slave (the comparator) returns status and the result.
interface seq_mag_compare_if #(
    parameter int WIDTH = 16
);
    localparam int IDX_W = $clog2(WIDTH);

    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             x;
    logic             y;
    logic             z;
    logic [IDX_W-1:0] diff_idx;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, x, y, z, diff_idx
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, x, y, z, diff_idx
    );

endinterface

// File: rtl/seq_mag_compare_cell.sv
// Single-bit cascade cell: decides greater/less for one bit position,
// with the sign bit's weight inverted in two's-complement mode.
module mag_cmp_cell (
    input  logic a_bit,
    input  logic b_bit,
    input  logic is_sign,
    output logic gt,
    output logic lt
);

    logic differ_s;

    assign differ_s = a_bit ^ b_bit;

    // On the sign bit a set bit marks the smaller operand.
    always_comb begin
        gt = 1'b0;
        lt = 1'b0;
        if (is_sign) begin
            gt = differ_s & b_bit;
            lt = differ_s & a_bit;
        end else begin
            gt = differ_s & a_bit;
            lt = differ_s & b_bit;
        end
    end

endmodule

// File: rtl/seq_mag_compare.sv
// Sequential magnitude comparator: scans one bit per cycle from the MSB
// through a single shared cascade cell and stops at the first difference.
module seq_mag_compare
    import compare_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    seq_mag_compare_if.slave bus
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);

    state_t           state_r, state_nxt_s;
    logic [WIDTH-1:0] a_r, a_nxt_s;
    logic [WIDTH-1:0] b_r, b_nxt_s;
    logic             sm_r, sm_nxt_s;
    logic [IDX_W-1:0] idx_r, idx_nxt_s;
    logic [2:0]       res_r, res_nxt_s;
    logic [IDX_W-1:0] diff_idx_r, diff_idx_nxt_s;
    logic             busy_r;
    logic             done_r;

    logic             cell_gt_s;
    logic             cell_lt_s;
    logic             is_sign_s;

    assign is_sign_s = sm_r & (idx_r == IDX_MSB);

    mag_cmp_cell u_cell (
        .a_bit   (a_r[idx_r]),
        .b_bit   (b_r[idx_r]),
        .is_sign (is_sign_s),
        .gt      (cell_gt_s),
        .lt      (cell_lt_s)
    );

    // Next-state, operand capture, scan counter and result resolution.
    always_comb begin
        state_nxt_s    = state_r;
        a_nxt_s        = a_r;
        b_nxt_s        = b_r;
        sm_nxt_s       = sm_r;
        idx_nxt_s      = idx_r;
        res_nxt_s      = res_r;
        diff_idx_nxt_s = diff_idx_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    a_nxt_s        = bus.a;
                    b_nxt_s        = bus.b;
                    sm_nxt_s       = bus.signed_mode;
                    idx_nxt_s      = IDX_MSB;
                    res_nxt_s      = RES_NONE;
                    diff_idx_nxt_s = IDX_ZERO;
                    state_nxt_s    = SCAN;
                end else begin
                    state_nxt_s    = IDLE;
                end
            end
            SCAN: begin
                if (cell_gt_s || cell_lt_s) begin
                    res_nxt_s      = cell_gt_s ? RES_GT : RES_LT;
                    diff_idx_nxt_s = idx_r;
                    state_nxt_s    = DONE;
                end else if (idx_r == IDX_ZERO) begin
                    res_nxt_s      = RES_EQ;
                    diff_idx_nxt_s = IDX_ZERO;
                    state_nxt_s    = DONE;
                end else begin
                    idx_nxt_s      = idx_r - IDX_W'(1);
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            a_r        <= '0;
            b_r        <= '0;
            sm_r       <= 1'b0;
            idx_r      <= IDX_ZERO;
            res_r      <= RES_NONE;
            diff_idx_r <= IDX_ZERO;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            a_r        <= a_nxt_s;
            b_r        <= b_nxt_s;
            sm_r       <= sm_nxt_s;
            idx_r      <= idx_nxt_s;
            res_r      <= res_nxt_s;
            diff_idx_r <= diff_idx_nxt_s;
            busy_r     <= (state_nxt_s != IDLE);
            done_r     <= (state_nxt_s == DONE);
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.x        = res_r[2];
    assign bus.y        = res_r[1];
    assign bus.z        = res_r[0];
    assign bus.diff_idx = diff_idx_r;

endmodule

// File: tb/tb_seq_mag_compare.sv
// Self-checking bench for seq_mag_compare (WIDTH=8): an arithmetic model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_seq_mag_compare;

    localparam int W = 8;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   edge_cnt;

    seq_mag_compare_if #(.WIDTH(W)) bus ();

    seq_mag_compare #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_cyc;
    int         m_acc;
    int         m_lat;
    bit         m_active;
    bit         e_busy;
    bit         e_done;
    logic [2:0] e_res;
    logic [2:0] e_idx;
    logic [2:0] p_res;
    logic [2:0] p_idx;

    task automatic model_eval(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                              output logic [2:0] res, output logic [2:0] idx, output int lat);
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        bit gt;
        bit found;
        sa = a;
        sb = b;
        gt = sm ? (sa > sb) : (a > b);
        res = (a == b) ? 3'b010 : (gt ? 3'b100 : 3'b001);
        idx = 3'd0;
        found = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (!found && (a[i] != b[i])) begin
                idx = 3'(i);
                found = 1'b1;
            end
        end
        lat = found ? (W - int'(idx)) : W;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0;
            e_res    = 3'b000;
            e_idx    = 3'd0;
            m_cyc    = 0;
        end else begin
            m_cyc++;
            if (m_active) begin
                if (m_cyc == m_acc + m_lat + 1) m_active = 1'b0;
            end else if (bus.start) begin
                model_eval(bus.a, bus.b, bus.signed_mode, p_res, p_idx, m_lat);
                m_acc    = m_cyc;
                m_active = 1'b1;
                e_res    = 3'b000;
                e_idx    = 3'd0;
            end
            if (m_active && m_cyc == m_acc + m_lat) begin
                e_res = p_res;
                e_idx = p_idx;
            end
        end
        e_busy = m_active;
        e_done = m_active && (m_cyc == m_acc + m_lat);
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        check("busy", bus.busy, e_busy);
        check("done", bus.done, e_done);
        check("xyz", {bus.x, bus.y, bus.z}, e_res);
        check("diff_idx", bus.diff_idx, e_idx);
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_done(output int at);
        bit ok;
        ok = 1'b0;
        at = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!ok && bus.done) begin
                at = edge_cnt;
                ok = 1'b1;
                break;
            end
        end
        check("done_timeout", ok, 1);
    endtask

    task automatic run_cmp(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic sm, input logic [2:0] exp_res,
                           input logic [2:0] exp_idx, input int exp_lat);
        int t0;
        int td;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.signed_mode = sm;
        @(negedge clk);
        t0 = edge_cnt;
        bus.start = 1'b0;
        wait_done(td);
        check({name, "_lat"}, td - t0, exp_lat);
        check({name, "_res"}, {bus.x, bus.y, bus.z}, exp_res);
        check({name, "_idx"}, bus.diff_idx, exp_idx);
        @(negedge clk);
        check({name, "_idle"}, bus.busy, 0);
    endtask

    initial begin
        int t0;
        int td;
        int n_done;
        int d_at[2];
        logic [2:0] d_res[2];
        logic [2:0] d_idx[2];

        tests = 0;
        fails = 0;
        edge_cnt = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.a = 8'h00;
        bus.b = 8'h00;
        bus.signed_mode = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_xyz", {bus.x, bus.y, bus.z}, 3'b000);
        check("rst_idx", bus.diff_idx, 0);
        rst = 1'b0;

        run_cmp("u_msb", 8'hA5, 8'h25, 1'b0, 3'b100, 3'd7, 1);
        run_cmp("s_msb", 8'hA5, 8'h25, 1'b1, 3'b001, 3'd7, 1);
        run_cmp("lsb",   8'h10, 8'h11, 1'b0, 3'b001, 3'd0, 8);
        run_cmp("eq_s",  8'h80, 8'h80, 1'b1, 3'b010, 3'd0, 8);
        run_cmp("mid_u", 8'h3C, 8'h34, 1'b0, 3'b100, 3'd3, 5);
        run_cmp("neg_s", 8'hF0, 8'h80, 1'b1, 3'b100, 3'd6, 2);

        // Start while busy is ignored; results then hold while inputs move.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h11; bus.signed_mode = 1'b0;
        @(negedge clk);
        t0 = edge_cnt;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'h00;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(td);
        check("busy_ign_lat", td - t0, 8);
        check("busy_ign_res", {bus.x, bus.y, bus.z}, 3'b001);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.a = 8'(k * 37);
            bus.b = 8'(~k);
            bus.signed_mode = ~bus.signed_mode;
            check("hold_res", {bus.x, bus.y, bus.z}, 3'b001);
            check("hold_done", bus.done, 0);
        end

        // Reset mid-scan aborts with no done.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h02; bus.signed_mode = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_xyz", {bus.x, bus.y, bus.z}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        check("abort_no_done", n_done, 0);
        run_cmp("post_rst", 8'h01, 8'h02, 1'b0, 3'b001, 3'd1, 7);

        // Back-to-back with start held high.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h7F; bus.b = 8'h80; bus.signed_mode = 1'b0;
        @(negedge clk);
        t0 = edge_cnt;
        bus.signed_mode = 1'b1;
        n_done = 0;
        for (int k = 0; k < 8; k++) begin
            if (edge_cnt == t0 + 3) bus.start = 1'b0;
            if (bus.done) begin
                if (n_done < 2) begin
                    d_at[n_done]  = edge_cnt;
                    d_res[n_done] = {bus.x, bus.y, bus.z};
                    d_idx[n_done] = bus.diff_idx;
                end
                n_done++;
            end
            @(negedge clk);
        end
        check("b2b_count", n_done, 2);
        if (n_done >= 2) begin
            check("b2b_first_at", d_at[0] - t0, 1);
            check("b2b_first_res", d_res[0], 3'b001);
            check("b2b_second_at", d_at[1] - t0, 4);
            check("b2b_second_res", d_res[1], 3'b100);
            check("b2b_second_idx", d_idx[1], 3'd7);
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
